// File: rtl/cordic_angle_reduce.sv
// cordic_angle_reduce
// Range reduction ahead of the CORDIC cosine core. Folds a wide signed radian
// angle into [-pi/2, pi/2] and flags when the downstream cosine must be negated.
// One conditional subtract of a binary multiple of 2pi per clock.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; ready high once out of reset
// S_REDUCE | strip 2pi<<i from |angle|, i = ITERS-1 down to 0
// S_WRAP   | map [0, 2pi) to [-pi, pi] and restore the input sign
// S_FOLD   | reflect |r| > pi/2 about +-pi/2, register result, pulse done
module cordic_angle_reduce #(
  parameter int     IN_WIDTH  = 40,
  parameter int     BIT_WIDTH = 32,
  parameter int     FRAC_BITS = 29,
  parameter int     ITERS     = 8,
  parameter longint PI        = 64'd1686629713,
  parameter longint HALF_PI   = 64'd843314857,
  parameter longint TWO_PI    = 64'd3373259426
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  angle,
  output logic [BIT_WIDTH-1:0] angle_out,
  output logic                 cos_negate,
  output logic                 ready,
  output logic                 done
);

  // Input and output share FRAC_BITS; the reduce loop only strips integer
  // multiples, so the fraction count must leave room for the integer part.
  if (FRAC_BITS < 2 || FRAC_BITS >= BIT_WIDTH || ITERS != IN_WIDTH - BIT_WIDTH) begin : g_param_check
    $error("cordic_angle_reduce: inconsistent FRAC_BITS/ITERS/width parameters");
  end

  // r carries one extra bit so +-(2^(IN_WIDTH-1)) and the sign flip stay exact.
  localparam int RW = IN_WIDTH + 1;
  // 2pi<<i may exceed IN_WIDTH bits for the top iterations of a generic config.
  localparam int SW = IN_WIDTH + ITERS;
  localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic signed [RW-1:0] C_PI      = RW'(PI);
  localparam logic signed [RW-1:0] C_HALF_PI = RW'(HALF_PI);
  localparam logic signed [RW-1:0] C_TWO_PI  = RW'(TWO_PI);
  localparam logic        [SW-1:0] C_TWO_PI_W = SW'(TWO_PI);
  localparam logic        [IW-1:0] C_I_LAST  = IW'(ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_WRAP, S_FOLD} state_t;

  state_t                 r_state;
  logic                   r_sign;
  logic [IN_WIDTH-1:0]    r_mag;
  logic [IW-1:0]          r_i;
  logic signed [RW-1:0]   r_r;
  logic [BIT_WIDTH-1:0]   r_angle_out;
  logic                   r_cos_negate;
  logic                   r_ready;
  logic                   r_done;

  logic [IN_WIDTH-1:0]    w_abs;
  logic [SW-1:0]          w_step;
  logic                   w_fits;
  logic [IN_WIDTH-1:0]    w_mag_sub;
  logic signed [RW-1:0]   w_mag_s;
  logic signed [RW-1:0]   w_wrap;
  logic signed [RW-1:0]   w_signed;
  logic signed [RW-1:0]   w_fold;
  logic                   w_fold_neg;

  // Unsigned magnitude: the most negative input maps to 2^(IN_WIDTH-1) exactly.
  assign w_abs     = angle[IN_WIDTH-1] ? (-angle) : angle;
  assign w_step    = C_TWO_PI_W << r_i;
  assign w_fits    = {{ITERS{1'b0}}, r_mag} >= w_step;
  // Only used when w_fits, so w_step fits in IN_WIDTH bits there.
  assign w_mag_sub = r_mag - IN_WIDTH'(w_step);
  assign w_mag_s   = signed'({1'b0, r_mag});
  assign w_wrap    = (w_mag_s > C_PI) ? (w_mag_s - C_TWO_PI) : w_mag_s;
  assign w_signed  = r_sign ? -w_wrap : w_wrap;

  // Reflect about +-pi/2 so the CORDIC only ever sees [-pi/2, pi/2].
  always_comb begin
    w_fold     = r_r;
    w_fold_neg = 1'b0;
    if (r_r > C_HALF_PI) begin
      w_fold     = C_PI - r_r;
      w_fold_neg = 1'b1;
    end else if (r_r < -C_HALF_PI) begin
      w_fold     = -C_PI - r_r;
      w_fold_neg = 1'b1;
    end
  end

  // Sequencer: handshake, iterative reduction, wrap and fold, all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sign       <= 1'b0;
      r_mag        <= '0;
      r_i          <= '0;
      r_r          <= '0;
      r_angle_out  <= '0;
      r_cos_negate <= 1'b0;
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_ready && start) begin
            r_sign  <= angle[IN_WIDTH-1];
            r_mag   <= w_abs;
            r_i     <= C_I_LAST;
            r_ready <= 1'b0;
            r_state <= S_REDUCE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_REDUCE: begin
          if (w_fits) r_mag <= w_mag_sub;
          if (r_i == '0) r_state <= S_WRAP;
          else           r_i     <= r_i - IW'(1);
        end
        S_WRAP: begin
          r_r     <= w_signed;
          r_state <= S_FOLD;
        end
        S_FOLD: begin
          r_angle_out  <= BIT_WIDTH'(w_fold);
          r_cos_negate <= w_fold_neg;
          r_done       <= 1'b1;
          r_ready      <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign angle_out  = r_angle_out;
  assign cos_negate = r_cos_negate;
  assign ready      = r_ready;
  assign done       = r_done;

endmodule

// File: tb/tb_cordic_angle_reduce.sv
// Testbench for cordic_angle_reduce: directed boundary cases, handshake corner
// cases and random angles against a modulo-arithmetic reference model.
module tb_cordic_angle_reduce;

  localparam longint PI    = 64'd1686629713;
  localparam longint HALF  = 64'd843314857;
  localparam longint TWO   = 64'd3373259426;
  localparam real    SCALE = 536870912.0;
  localparam real    RPI   = 3.141592653589793;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [39:0] angle = '0;
  logic [31:0] angle_out;
  logic        cos_negate;
  logic        ready;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  cordic_angle_reduce dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .angle      (angle),
    .angle_out  (angle_out),
    .cos_negate (cos_negate),
    .ready      (ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: |angle| mod 2pi, centre on [-pi, pi], reapply sign, reflect.
  function automatic void model(input longint a, output longint o, output longint n);
    longint m;
    longint r;
    m = (a < 0) ? -a : a;
    m = m % TWO;
    r = (m > PI) ? m - TWO : m;
    if (a < 0) r = -r;
    if (r > HALF) begin
      o = PI - r; n = 1;
    end else if (r < -HALF) begin
      o = -PI - r; n = 1;
    end else begin
      o = r; n = 0;
    end
  endfunction

  function automatic real ideal_out(input longint a);
    real x;
    real y;
    x = real'(a) / SCALE;
    y = x - 2.0 * RPI * $floor(x / (2.0 * RPI) + 0.5);
    if (y > RPI / 2.0)       return RPI - y;
    else if (y < -RPI / 2.0) return -RPI - y;
    return y;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input longint a);
    longint eo;
    longint en;
    longint got;
    real    d;
    real    c0;
    real    c1;
    model(a, eo, en);
    got = longint'($signed(angle_out));
    check({tag, "/out"}, got, eo);
    check({tag, "/neg"}, cos_negate, en);
    check({tag, "/range"}, (got <= HALF && got >= -HALF), 1);
    c0 = $cos(real'(a) / SCALE);
    c1 = $cos(real'(got) / SCALE) * (cos_negate ? -1.0 : 1.0);
    check({tag, "/cos"}, (c1 - c0 < 1.0e-6 && c0 - c1 < 1.0e-6), 1);
    if (a < 64'sd8589934592 && a > -64'sd8589934592) begin
      d = ideal_out(a) * SCALE - real'(got);
      check({tag, "/ideal"}, (d <= 2.0 && d >= -2.0), 1);
    end
  endtask

  task automatic run_op(input longint a, input string tag);
    int cyc;
    angle = a[39:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    angle = ~angle;
    wait_done(cyc);
    check({tag, "/lat"}, cyc, 10);
    check({tag, "/rdy"}, ready, 1);
    check_result(tag, a);
    tick();
    check({tag, "/pulse"}, done, 0);
  endtask

  initial begin
    int           cyc;
    int           ndone;
    longint       a;
    logic [63:0]  v64;
    logic signed [39:0] sv;

    reset = 1'b0;
    tick(); tick();
    check("rst/ready", ready, 0);
    check("rst/done", done, 0);
    check("rst/out", angle_out, 0);
    check("rst/neg", cos_negate, 0);
    reset = 1'b1;
    tick();
    check("rst/ready_rise", ready, 1);

    run_op(0, "zero");
    run_op(PI, "pi");
    run_op(-PI, "mpi");
    run_op(HALF, "half");
    run_op(-HALF, "mhalf");
    run_op(HALF + 1, "half_p1");
    run_op(64'sd5368709120, "ten");
    run_op(-(64'sd1 <<< 39), "most_neg");
    run_op((64'sd1 <<< 39) - 1, "most_pos");

    // Extra starts while busy are ignored.
    a = 64'sd2000000000;
    angle = a[39:0]; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    angle = 40'd999999; start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(cyc);
    check("ign/lat", cyc + 7, 10);
    check_result("ign", a);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("ign/single_done", ndone, 0);

    // Start in the done cycle is accepted.
    a = -64'sd3000000000;
    angle = a[39:0]; start = 1'b1; tick(); start = 1'b0;
    wait_done(cyc);
    check("b2b/lat1", cyc, 10);
    check_result("b2b1", a);
    a = 64'sd7000000000;
    angle = a[39:0]; start = 1'b1; tick(); start = 1'b0;
    wait_done(cyc);
    check("b2b/lat2", cyc, 10);
    check_result("b2b2", a);
    tick();

    // Reset mid-reduction abandons the operation.
    run_op(64'sd5368709120, "pre_rst");
    a = 64'sd123456789012;
    angle = a[39:0]; start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b0; tick(); reset = 1'b1;
    check("mrst/done", done, 0);
    check("mrst/out", angle_out, 0);
    check("mrst/neg", cos_negate, 0);
    check("mrst/ready0", ready, 0);
    tick();
    check("mrst/ready1", ready, 1);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("mrst/no_done", ndone, 0);
    run_op(-64'sd4000000000, "post_rst");

    for (int k = 0; k < 24; k++) begin
      v64 = {$urandom, $urandom};
      sv = v64[39:0];
      a = sv;
      run_op(a, "rnd_wide");
    end
    for (int k = 0; k < 24; k++) begin
      a = longint'($urandom) * 2 - 64'sd4294967296;
      run_op(a, "rnd_small");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
